dm_arb_seq: RTL and testbench

- Controller that shares a single byte-wide data-memory port between two requesters: port 0 is the CPU MEM stage, port 1 is the debug/DMA loader.
- Arbitrates between the two requesters.
- Splits each word or halfword access into a sequence of single-byte memory cycles.
- Assembles and extends read data, then returns one completion pulse per access.
- Sits between the pipeline MEM stage and the byte-addressed data memory array.

---
 rtl/dm_arb_seq.sv | 174 +++++++++++++++++
 tb/tb_dm_arb_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arb_seq.sv
// rtl/dm_arb_seq.sv - two-port arbiter that sequences word/half/byte accesses onto a byte-wide data memory
module dm_arb_seq #(
  parameter int AW = 9,
  parameter bit RR = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  input  logic [2:0]    type0,
  input  logic [2:0]    type1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  output logic [31:0]   rdata,
  output logic          busy,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [7:0]    m_wdata,
  input  logic [7:0]    m_rdata
);

  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_HALFU = 3'b010;
  localparam logic [2:0] DM_BYTE  = 3'b011;
  localparam logic [2:0] DM_BYTEU = 3'b100;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t        state, state_nxt;
  logic          owner, we_q, err_q, last_gnt;
  logic [2:0]    type_q;
  logic [1:0]    k, k_last;
  logic [31:0]   wsh, asm, rdata_q;
  logic          any_req, win, sel_we;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic [2:0]    sel_type;

  function automatic logic type_ok(input logic [2:0] t);
    return t <= DM_BYTEU;
  endfunction

  function automatic logic [1:0] last_idx(input logic [2:0] t);
    case (t)
      DM_WORD:           last_idx = 2'd3;
      DM_HALF, DM_HALFU: last_idx = 2'd1;
      default:           last_idx = 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] t);
    case (t)
      DM_BYTE:  extend = {{24{v[7]}}, v[7:0]};
      DM_BYTEU: extend = {24'h0, v[7:0]};
      DM_HALF:  extend = {{16{v[15]}}, v[15:0]};
      DM_HALFU: extend = {16'h0, v[15:0]};
      default:  extend = v;
    endcase
  endfunction

  // last_gnt names the port served most recently; a tie goes to the other one
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) win = RR ? ~last_gnt : 1'b0;
    else              win = req1;
    sel_we    = win ? we1    : we0;
    sel_addr  = win ? addr1  : addr0;
    sel_wdata = win ? wdata1 : wdata0;
    sel_type  = win ? type1  : type0;
    k_last    = last_idx(type_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = type_ok(sel_type) ? XFER : DONE;
      XFER:    if (k == k_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      last_gnt <= 1'b1;
      type_q   <= 3'b000;
      k        <= 2'd0;
      wsh      <= 32'h0;
      asm      <= 32'h0;
      rdata_q  <= 32'h0;
      m_addr   <= '0;
      m_wdata  <= 8'h00;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          owner    <= win;
          last_gnt <= win;
          we_q     <= sel_we;
          type_q   <= sel_type;
          err_q    <= ~type_ok(sel_type);
          k        <= 2'd0;
          asm      <= 32'h0;
          if (type_ok(sel_type)) begin
            m_addr <= sel_addr;
            if (sel_we) begin
              m_wdata <= sel_wdata[7:0];
              wsh     <= sel_wdata >> 8;
            end
          end
        end
        XFER: begin
          if (!we_q) asm[{k, 3'b000} +: 8] <= m_rdata;
          if (k != k_last) begin
            k      <= k + 2'd1;
            m_addr <= m_addr + AW'(1);
            if (we_q) begin
              m_wdata <= wsh[7:0];
              wsh     <= wsh >> 8;
            end
          end
        end
        DONE: if (!we_q || err_q) rdata_q <= rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    err0  = 1'b0;
    err1  = 1'b0;
    rdata = rdata_q;
    busy  = (state != IDLE);
    m_we  = (state == XFER) && we_q;
    case (state)
      IDLE: if (any_req) begin
        gnt0 = ~win;
        gnt1 = win;
      end
      DONE: begin
        done0 = ~owner;
        done1 = owner;
        err0  = ~owner & err_q;
        err1  = owner & err_q;
        if (err_q)      rdata = 32'hFFFF_FFFF;
        else if (!we_q) rdata = extend(asm, type_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dm_arb_seq.sv
// tb/tb_dm_arb_seq.sv - self-checking bench for dm_arb_seq: vector table, corner sequences, random vs. byte-memory model
module tb_dm_arb_seq;

  localparam logic [2:0] T_W = 3'd0, T_H = 3'd1, T_HU = 3'd2, T_B = 3'd3, T_BU = 3'd4, T_BAD = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [8:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [2:0]  type0 = '0, type1 = '0;
  logic gnt0, gnt1, done0, done1, err0, err1, busy, m_we;
  logic [31:0] rdata;
  logic [8:0]  m_addr;
  logic [7:0]  m_wdata, m_rdata;

  logic fp_req0 = 1'b0, fp_req1 = 1'b0;
  logic fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_err0, fp_err1, fp_busy, fp_m_we;
  logic [31:0] fp_rdata;
  logic [8:0]  fp_m_addr;
  logic [7:0]  fp_m_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  mem [512];
  logic [7:0]  ref_mem [512];
  logic [31:0] ref_rdata = 32'h0;

  typedef struct {int c; logic [8:0] a; logic [7:0] d;} wr_t;
  wr_t wrq[$];

  typedef struct {bit p; bit w; logic [8:0] a; logic [31:0] d; logic [2:0] t; logic [31:0] er; bit ee;} vec_t;
  vec_t tbl[13];

  dm_arb_seq #(.AW(9), .RR(1'b1)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .type0(type0), .type1(type1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata(rdata), .busy(busy), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  dm_arb_seq #(.AW(9), .RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .req0(fp_req0), .req1(fp_req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .type0(type0), .type1(type1),
    .gnt0(fp_gnt0), .gnt1(fp_gnt1), .done0(fp_done0), .done1(fp_done1), .err0(fp_err0), .err1(fp_err1),
    .rdata(fp_rdata), .busy(fp_busy), .m_we(fp_m_we), .m_addr(fp_m_addr), .m_wdata(fp_m_wdata), .m_rdata(8'h00)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (m_we) mem[m_addr] <= m_wdata;
  assign m_rdata = mem[m_addr];
  always @(negedge clk) if (m_we) wrq.push_back('{cyc, m_addr, m_wdata});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [2:0] t);
    case (t)
      T_W:        return 4;
      T_H, T_HU:  return 2;
      T_B, T_BU:  return 1;
      default:    return 0;
    endcase
  endfunction

  // Little-endian gather from the reference memory, then two's-complement wrap for signed types
  function automatic logic [31:0] model_load(input logic [8:0] a, input logic [2:0] t);
    longint v;
    int n;
    v = 0;
    n = nbytes(t);
    for (int k = 0; k < n; k++) v += longint'(ref_mem[(int'(a) + k) % 512]) << (8 * k);
    if ((t == T_B || t == T_H) && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic model_access(input bit w, input logic [8:0] a, input logic [31:0] d, input logic [2:0] t,
                              output logic [31:0] er, output bit ee);
    int n;
    n = nbytes(t);
    ee = (n == 0);
    if (ee) ref_rdata = 32'hFFFF_FFFF;
    else if (w) for (int k = 0; k < n; k++) ref_mem[(int'(a) + k) % 512] = d[8 * k +: 8];
    else ref_rdata = model_load(a, t);
    er = ref_rdata;
  endtask

  task automatic drive(input bit p, input bit on, input bit w, input logic [8:0] a, input logic [31:0] d, input logic [2:0] t);
    if (!p) begin req0 = on; we0 = w; addr0 = a; wdata0 = d; type0 = t; end
    else    begin req1 = on; we1 = w; addr1 = a; wdata1 = d; type1 = t; end
  endtask

  task automatic run_access(input string tag, input bit p, input bit w, input logic [8:0] a, input logic [31:0] d,
                            input logic [2:0] t, output logic [31:0] got_rd, output bit got_err);
    logic [31:0] er;
    bit ee, got_g, got_d;
    int n, tg, td, waited, nw;
    n = nbytes(t);
    model_access(w, a, d, t, er, ee);
    wrq.delete();
    got_g = 0; got_d = 0; waited = 0; tg = 0; td = 0; got_rd = '0; got_err = 0;
    drive(p, 1'b1, w, a, d, t);
    while (!got_g && waited < 20) begin
      @(negedge clk);
      if (p ? gnt1 : gnt0) begin
        got_g = 1;
        tg = cyc;
        chk({tag, " other_gnt"}, p ? gnt0 : gnt1, 0);
      end else waited++;
    end
    chk({tag, " gnt_wait"}, waited, 0);
    @(posedge clk); #1;
    drive(p, 1'b0, w, a, d, t);
    if (!got_g) return;
    for (int i = 0; i < 20 && !got_d; i++) begin
      @(negedge clk);
      if (p ? done1 : done0) begin
        got_d = 1;
        td = cyc;
        got_rd = rdata;
        got_err = p ? err1 : err0;
        chk({tag, " busy_at_done"}, busy, 1);
        chk({tag, " other_done"}, p ? done0 : done1, 0);
      end
    end
    chk({tag, " done_seen"}, got_d, 1);
    chk({tag, " latency"}, td - tg, n + 1);
    chk({tag, " rdata"}, got_rd, er);
    chk({tag, " err"}, got_err, ee);
    nw = (w && n > 0) ? n : 0;
    chk({tag, " n_writes"}, wrq.size(), nw);
    foreach (wrq[k]) if (k < nw) begin
      chk({tag, " wr_addr"}, wrq[k].a, (int'(a) + k) % 512);
      chk({tag, " wr_data"}, wrq[k].d, d[8 * k +: 8]);
      chk({tag, " wr_cycle"}, wrq[k].c, tg + 1 + k);
    end
    @(posedge clk); #1;
    chk({tag, " rdata_hold"}, rdata, er);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit e;
    int gp[$], gc[$], fpn, fp1, tg, ndone;
    bit p, w;
    logic [2:0] t;

    tbl[0]  = '{1'b0, 1'b1, 9'h010, 32'h8BADF00D, T_W,   32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 9'h010, 32'h0,        T_W,   32'h8BADF00D, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 9'h010, 32'h0000FF80, T_H,   32'h8BADF00D, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 9'h010, 32'h0,        T_B,   32'hFFFFFF80, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 9'h010, 32'h0,        T_BU,  32'h00000080, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 9'h010, 32'h0,        T_H,   32'hFFFFFF80, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 9'h010, 32'h0,        T_HU,  32'h0000FF80, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 9'h1FF, 32'h00001234, T_H,   32'h0000FF80, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 9'h1FF, 32'h0,        T_HU,  32'h00001234, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 9'h020, 32'hCAFEF00D, T_BAD, 32'hFFFFFFFF, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 9'h1FE, 32'h0,        T_W,   32'h00123400, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 9'h005, 32'hFFFFFFA5, T_BU,  32'h00123400, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 9'h005, 32'h0,        T_B,   32'hFFFFFFA5, 1'b0};

    for (int i = 0; i < 512; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset gnt", {gnt0, gnt1}, 0);
    chk("reset done_err", {done0, done1, err0, err1}, 0);
    chk("reset busy_mwe", {busy, m_we}, 0);
    chk("reset m_addr", m_addr, 0);
    chk("reset m_wdata", m_wdata, 0);
    chk("reset rdata", rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Both ports hold byte-store requests; RR alternates, fixed priority serves port 0 only
    drive(1'b0, 1'b1, 1'b1, 9'h040, 32'h11, T_B);
    drive(1'b1, 1'b1, 1'b1, 9'h041, 32'h22, T_B);
    fp_req0 = 1'b1; fp_req1 = 1'b1;
    fpn = 0; fp1 = 0;
    for (int i = 0; i < 40 && gp.size() < 5; i++) begin
      @(negedge clk);
      if (gnt0 && gnt1) chk("contend both_gnt", 1, 0);
      if (gnt0) begin gp.push_back(0); gc.push_back(cyc); end
      if (gnt1) begin gp.push_back(1); gc.push_back(cyc); end
      if (fp_gnt0) fpn++;
      if (fp_gnt1) fp1++;
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 9'h040, 32'h11, T_B);
    drive(1'b1, 1'b0, 1'b1, 9'h041, 32'h22, T_B);
    fp_req0 = 1'b0; fp_req1 = 1'b0;
    chk("contend n_grants", gp.size(), 5);
    foreach (gp[i]) chk("contend rr_order", gp[i], i % 2);
    for (int i = 1; i < gc.size(); i++) chk("contend spacing", gc[i] - gc[i-1], 3);
    chk("fixed port0_grants", fpn, 5);
    chk("fixed port1_grants", fp1, 0);
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    chk("contend idle_after", {busy, fp_busy}, 0);
    ref_mem[9'h040] = 8'h11;
    ref_mem[9'h041] = 8'h22;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run_access($sformatf("vec%0d", i), tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].t, rd, e);
      chk($sformatf("vec%0d table_rdata", i), rd, tbl[i].er);
      chk($sformatf("vec%0d table_err", i), e, tbl[i].ee);
    end
    chk("wrap mem_1ff", mem[9'h1FF], 8'h34);
    chk("wrap mem_000", mem[9'h000], 8'h12);

    // Reset sampled at the end of T+2 of a word store: two bytes land, no completion
    wrq.delete();
    drive(1'b0, 1'b1, 1'b1, 9'h100, 32'hAABBCCDD, T_W);
    @(negedge clk);
    chk("rstmid gnt0", gnt0, 1);
    tg = cyc;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 9'h100, 32'hAABBCCDD, T_W);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid cycle", cyc - tg, 3);
    chk("rstmid busy", busy, 0);
    chk("rstmid m_we", m_we, 0);
    chk("rstmid m_addr", m_addr, 0);
    chk("rstmid rdata", rdata, 0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      if (done0 || done1) ndone++;
      @(negedge clk);
    end
    chk("rstmid no_done", ndone, 0);
    chk("rstmid n_writes", wrq.size(), 2);
    chk("rstmid mem_100", mem[9'h100], 8'hDD);
    chk("rstmid mem_101", mem[9'h101], 8'hCC);
    chk("rstmid mem_102", mem[9'h102], ref_mem[9'h102]);
    chk("rstmid mem_103", mem[9'h103], ref_mem[9'h103]);
    ref_mem[9'h100] = 8'hDD;
    ref_mem[9'h101] = 8'hCC;
    ref_rdata = 32'h0;
    @(posedge clk); #1;
    run_access("rstmid reload", 1'b1, 1'b0, 9'h100, 32'h0, T_W, rd, e);

    for (int i = 0; i < 150; i++) begin
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      t = 3'($urandom_range(0, 5));
      if (t == 3'd5) t = 3'($urandom_range(5, 7));
      run_access($sformatf("rnd%0d", i), p, w, 9'($urandom_range(0, 511)), $urandom, t, rd, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
